// File: rtl/key_entry_decoder.sv
// Keypad event decoder and HHMM time-entry buffer, downstream of the keypad scanner.
// Optional macro KEY_REPEAT_EN adds auto-repeat while a key is held.
module key_entry_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_PERIOD   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_pressed_flag,
  input  logic [3:0]  col_val,
  input  logic [3:0]  row_val,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic        set_valid,
  output logic [7:0]  set_hour,
  output logic [7:0]  set_min,
  output logic        set_error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    WAIT_PRESS = 3'd0,
    DEBOUNCE_P = 3'd1,
    EMIT       = 3'd2,
    HOLD       = 3'd3,
    DEBOUNCE_R = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  generate
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_MAX ||
        longint'(REPEAT_DELAY) > CNT_MAX || longint'(REPEAT_PERIOD) > CNT_MAX) begin : g_bad_cfg
      $error("key_entry_decoder: CNT_W too narrow for the configured cycle counts");
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_1, flag_s;
  logic [1:0]       col_idx, row_idx;
  logic             col_ok, row_ok;
  logic [3:0]       dec_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      flag_s <= 1'b0;
    end else begin
      sync_1 <= key_pressed_flag;
      flag_s <= sync_1;
    end
  end

  always_comb begin
    col_idx = 2'd0;
    col_ok  = 1'b1;
    case (col_val)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_ok  = 1'b0;
    endcase
    row_idx = 2'd0;
    row_ok  = 1'b1;
    case (row_val)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_ok  = 1'b0;
    endcase
    case ({row_idx, col_idx})
      4'd0:    dec_code = 4'h1;
      4'd1:    dec_code = 4'h2;
      4'd2:    dec_code = 4'h3;
      4'd3:    dec_code = 4'hA;
      4'd4:    dec_code = 4'h4;
      4'd5:    dec_code = 4'h5;
      4'd6:    dec_code = 4'h6;
      4'd7:    dec_code = 4'hB;
      4'd8:    dec_code = 4'h7;
      4'd9:    dec_code = 4'h8;
      4'd10:   dec_code = 4'h9;
      4'd11:   dec_code = 4'hC;
      4'd12:   dec_code = 4'hE;
      4'd13:   dec_code = 4'h0;
      4'd14:   dec_code = 4'hF;
      default: dec_code = 4'hD;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic rep_started, code_ok;
`endif

  // key_valid is raised on the edge that enters EMIT, so it is high exactly while state == EMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_PRESS;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
`ifdef KEY_REPEAT_EN
      rep_started <= 1'b0;
      code_ok     <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        WAIT_PRESS: begin
          cnt <= '0;
          if (flag_s) state <= DEBOUNCE_P;
        end
        DEBOUNCE_P: begin
          if (!flag_s) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
          end else if (cnt >= DB_LAST) begin
            state <= EMIT;
            cnt   <= '0;
            if (col_ok && row_ok) begin
              key_valid <= 1'b1;
              key_code  <= dec_code;
            end
`ifdef KEY_REPEAT_EN
            code_ok <= col_ok && row_ok;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EMIT: begin
          state <= HOLD;
`ifdef KEY_REPEAT_EN
          cnt         <= CNT_W'(1);
          rep_started <= 1'b0;
`else
          cnt <= '0;
`endif
        end
        HOLD: begin
          if (!flag_s) begin
            state <= DEBOUNCE_R;
            cnt   <= CNT_W'(1);
          end
`ifdef KEY_REPEAT_EN
          else if ((!rep_started && cnt >= RD_LAST) || (rep_started && cnt >= RP_LAST)) begin
            key_valid   <= code_ok;
            rep_started <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DEBOUNCE_R: begin
          if (flag_s) begin
            state <= HOLD;
            cnt   <= '0;
`ifdef KEY_REPEAT_EN
            rep_started <= 1'b0;
`endif
          end else if (cnt >= DB_LAST) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= WAIT_PRESS;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

  // Entry buffer: digits only ever hold 0-9, so a plain hex compare is a valid BCD range check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 16'h0;
      digit_count <= 3'd0;
      set_valid   <= 1'b0;
      set_error   <= 1'b0;
      set_hour    <= 8'h0;
      set_min     <= 8'h0;
    end else begin
      set_valid <= 1'b0;
      set_error <= 1'b0;
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (digit_count == 3'd4) begin
            set_error <= 1'b1;
          end else begin
            digits      <= {digits[11:0], key_code};
            digit_count <= digit_count + 3'd1;
          end
        end else begin
          case (key_code)
            4'hA: begin
              if (digit_count == 3'd4 && digits[15:8] <= 8'h23 && digits[7:0] <= 8'h59) begin
                set_hour    <= digits[15:8];
                set_min     <= digits[7:0];
                set_valid   <= 1'b1;
                digits      <= 16'h0;
                digit_count <= 3'd0;
              end else begin
                set_error <= 1'b1;
              end
            end
            4'hB: begin
              if (digit_count != 3'd0) begin
                digits      <= {4'h0, digits[15:4]};
                digit_count <= digit_count - 3'd1;
              end
            end
            4'hC: begin
              digits      <= 16'h0;
              digit_count <= 3'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_key_entry_decoder.sv
// Bench for key_entry_decoder: directed table, multi-cycle corner sequences and randomized keys vs. a queue model.
module tb_key_entry_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flag = 1'b0;
  logic [3:0]  col = 4'hF;
  logic [3:0]  row = 4'hF;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        set_valid;
  logic [7:0]  set_hour;
  logic [7:0]  set_min;
  logic        set_error;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  key_entry_decoder #(
    .DEBOUNCE_CYCLES(16),
    .CNT_W(16),
    .REPEAT_DELAY(100),
    .REPEAT_PERIOD(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_pressed_flag(flag),
    .col_val(col),
    .row_val(row),
    .key_valid(key_valid),
    .key_code(key_code),
    .digits(digits),
    .digit_count(digit_count),
    .set_valid(set_valid),
    .set_hour(set_hour),
    .set_min(set_min),
    .set_error(set_error),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor results for the most recent press
  int kv_n, sv_n, se_n, both_n;
  int kv_cyc[$];

  task automatic clear_mon();
    kv_n = 0; sv_n = 0; se_n = 0; both_n = 0;
    kv_cyc.delete();
  endtask

  task automatic step(input int cyc);
    @(posedge clk);
    #1;
    if (key_valid) begin
      kv_n++;
      kv_cyc.push_back(cyc);
    end
    if (set_valid) sv_n++;
    if (set_error) se_n++;
    if (set_valid && set_error) both_n++;
  endtask

  // Called at #1 after a posedge; cycle 1 is the first edge that sees the flag high
  task automatic press(input logic [3:0] c_v, input logic [3:0] r_v, input int hold, input int rel);
    clear_mon();
    col  = c_v;
    row  = r_v;
    flag = 1'b1;
    for (int i = 1; i <= hold; i++) step(i);
    flag = 1'b0;
    for (int i = hold + 1; i <= hold + rel; i++) step(i);
    col = 4'hF;
    row = 4'hF;
  endtask

  string keymap = "123A456B789CE0FD";

  task automatic key_pins(input int code, output logic [3:0] c_v, output logic [3:0] r_v);
    logic [3:0] one;
    int chv, val;
    one = 4'b0001;
    c_v = 4'hF;
    r_v = 4'hF;
    for (int i = 0; i < 16; i++) begin
      chv = int'(keymap[i]);
      val = (chv >= 48 && chv <= 57) ? chv - 48 : chv - 55;
      if (val == code) begin
        c_v = ~(one << (i % 4));
        r_v = ~(one << (i / 4));
      end
    end
  endtask

  // Reference model: digit queue, decimal-range commit rule
  int         mq[$];
  logic [7:0] m_hour = 8'h0;
  logic [7:0] m_min  = 8'h0;
  logic [3:0] m_code = 4'h0;
  int         m_sv, m_se;

  task automatic model_key(input int k);
    m_sv = 0;
    m_se = 0;
    m_code = 4'(k);
    if (k <= 9) begin
      if (mq.size() == 4) m_se = 1;
      else mq.push_back(k);
    end else if (k == 10) begin
      if (mq.size() == 4 && mq[0] * 10 + mq[1] <= 23 && mq[2] * 10 + mq[3] <= 59) begin
        m_hour = 8'(mq[0] * 16 + mq[1]);
        m_min  = 8'(mq[2] * 16 + mq[3]);
        m_sv   = 1;
        mq.delete();
      end else begin
        m_se = 1;
      end
    end else if (k == 11) begin
      if (mq.size() > 0) void'(mq.pop_back());
    end else if (k == 12) begin
      mq.delete();
    end
  endtask

  function automatic logic [15:0] model_digits();
    int v;
    v = 0;
    foreach (mq[i]) v = v * 16 + mq[i];
    return 16'(v);
  endfunction

  task automatic model_press(input int k, input int hold);
    logic [3:0] c_v, r_v;
    key_pins(k, c_v, r_v);
    press(c_v, r_v, hold, 30);
    if (hold >= 20) model_key(k);
    else begin
      m_sv = 0;
      m_se = 0;
    end
    check("rand_kv_count", kv_n, (hold >= 20) ? 1 : 0);
    check("rand_key_code", key_code, m_code);
    check("rand_digits", digits, model_digits());
    check("rand_digit_count", digit_count, mq.size());
    check("rand_set_valid", sv_n, m_sv);
    check("rand_set_error", se_n, m_se);
    check("rand_set_hour", set_hour, m_hour);
    check("rand_set_min", set_min, m_min);
    check("rand_valid_error_overlap", both_n, 0);
  endtask

  typedef struct {
    logic [3:0]  key;
    logic [15:0] dig;
    int          cnt;
    int          sv;
    int          se;
    logic [7:0]  hh;
    logic [7:0]  mm;
  } vec_t;

  vec_t tbl[24];

  initial begin
    logic [3:0] c_v, r_v;
    int hh, mm, k, hold;
    int rep_exp[5];

    tbl[0]  = '{4'hC, 16'h0000, 0, 0, 0, 8'h00, 8'h00};
    tbl[1]  = '{4'hB, 16'h0000, 0, 0, 0, 8'h00, 8'h00};
    tbl[2]  = '{4'h1, 16'h0001, 1, 0, 0, 8'h00, 8'h00};
    tbl[3]  = '{4'hD, 16'h0001, 1, 0, 0, 8'h00, 8'h00};
    tbl[4]  = '{4'h2, 16'h0012, 2, 0, 0, 8'h00, 8'h00};
    tbl[5]  = '{4'hE, 16'h0012, 2, 0, 0, 8'h00, 8'h00};
    tbl[6]  = '{4'h3, 16'h0123, 3, 0, 0, 8'h00, 8'h00};
    tbl[7]  = '{4'hF, 16'h0123, 3, 0, 0, 8'h00, 8'h00};
    tbl[8]  = '{4'h0, 16'h1230, 4, 0, 0, 8'h00, 8'h00};
    tbl[9]  = '{4'hA, 16'h0000, 0, 1, 0, 8'h12, 8'h30};
    tbl[10] = '{4'h2, 16'h0002, 1, 0, 0, 8'h12, 8'h30};
    tbl[11] = '{4'h5, 16'h0025, 2, 0, 0, 8'h12, 8'h30};
    tbl[12] = '{4'h0, 16'h0250, 3, 0, 0, 8'h12, 8'h30};
    tbl[13] = '{4'h0, 16'h2500, 4, 0, 0, 8'h12, 8'h30};
    tbl[14] = '{4'hA, 16'h2500, 4, 0, 1, 8'h12, 8'h30};
    tbl[15] = '{4'hB, 16'h0250, 3, 0, 0, 8'h12, 8'h30};
    tbl[16] = '{4'hB, 16'h0025, 2, 0, 0, 8'h12, 8'h30};
    tbl[17] = '{4'hC, 16'h0000, 0, 0, 0, 8'h12, 8'h30};
    tbl[18] = '{4'h1, 16'h0001, 1, 0, 0, 8'h12, 8'h30};
    tbl[19] = '{4'h1, 16'h0011, 2, 0, 0, 8'h12, 8'h30};
    tbl[20] = '{4'h1, 16'h0111, 3, 0, 0, 8'h12, 8'h30};
    tbl[21] = '{4'h1, 16'h1111, 4, 0, 0, 8'h12, 8'h30};
    tbl[22] = '{4'h9, 16'h1111, 4, 0, 1, 8'h12, 8'h30};
    tbl[23] = '{4'hC, 16'h0000, 0, 0, 0, 8'h12, 8'h30};

    // Clock/reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_key_valid", key_valid, 0);
    check("reset_key_code", key_code, 0);
    check("reset_digits", digits, 0);
    check("reset_digit_count", digit_count, 0);
    check("reset_set_outputs", {set_valid, set_error, set_hour, set_min}, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Key 8 held 40 cycles: single event, fixed latency
    press(4'b1101, 4'b1011, 40, 30);
    check("key8_kv_count", kv_n, 1);
    check("key8_latency", (kv_cyc.size() > 0) ? kv_cyc[0] : -1, 19);
    check("key8_key_code", key_code, 4'h8);
    check("key8_digits", digits, 16'h0008);
    model_key(8);

    // Directed table
    for (int i = 0; i < 24; i++) begin
      key_pins(tbl[i].key, c_v, r_v);
      press(c_v, r_v, 40, 30);
      model_key(tbl[i].key);
      check($sformatf("tbl%0d_kv_count", i), kv_n, 1);
      check($sformatf("tbl%0d_key_code", i), key_code, tbl[i].key);
      check($sformatf("tbl%0d_digits", i), digits, tbl[i].dig);
      check($sformatf("tbl%0d_digit_count", i), digit_count, tbl[i].cnt);
      check($sformatf("tbl%0d_set_valid", i), sv_n, tbl[i].sv);
      check($sformatf("tbl%0d_set_error", i), se_n, tbl[i].se);
      check($sformatf("tbl%0d_set_hour", i), set_hour, tbl[i].hh);
      check($sformatf("tbl%0d_set_min", i), set_min, tbl[i].mm);
    end

    // Flag glitch of 10 cycles: no event, back to idle
    press(4'b1101, 4'b1101, 10, 30);
    check("glitch_kv_count", kv_n, 0);
    check("glitch_key_code", key_code, 4'hC);
    check("glitch_state", dbg_state, 0);

    // Invalid patterns: two zeros, no zero
    press(4'b1100, 4'b1011, 40, 30);
    check("invalid_col_kv_count", kv_n, 0);
    check("invalid_col_key_code", key_code, 4'hC);
    check("invalid_col_state", dbg_state, 0);
    press(4'b1111, 4'b0111, 40, 30);
    check("invalid_row_kv_count", kv_n, 0);
    check("invalid_row_digits", digits, 16'h0000);

    // Randomized keys against the model
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k < 6) k = $urandom_range(0, 9);
      else if (k == 6) k = 10;
      else if (k == 7) k = 11;
      else if (k == 8) k = 12;
      else k = $urandom_range(13, 15);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 12) : $urandom_range(20, 45);
      model_press(k, hold);
    end
    for (int i = 0; i < 10; i++) begin
      hh = $urandom_range(0, 29);
      mm = $urandom_range(0, 69);
      model_press(12, 25);
      model_press(hh / 10, 25);
      model_press(hh % 10, 25);
      model_press(mm / 10, 25);
      model_press(mm % 10, 25);
      model_press(10, 25);
    end

    // Reset in the middle of an entry and a debounce
    model_press(4, 25);
    model_press(7, 25);
    key_pins(1, c_v, r_v);
    clear_mon();
    col = c_v;
    row = r_v;
    flag = 1'b1;
    for (int i = 1; i <= 10; i++) step(i);
    #2 rst = 1'b1;
    #1;
    check("midreset_digits", digits, 0);
    check("midreset_digit_count", digit_count, 0);
    check("midreset_set_hold", {set_hour, set_min}, 0);
    check("midreset_state", dbg_state, 0);
    step(11);
    rst = 1'b0;
    for (int i = 12; i <= 40; i++) step(i);
    flag = 1'b0;
    col = 4'hF;
    row = 4'hF;
    for (int i = 41; i <= 70; i++) step(i);
    check("midreset_kv_count", kv_n, 1);
    check("midreset_no_set_pulse", sv_n + se_n, 0);
    mq.delete();
    m_hour = 8'h0;
    m_min  = 8'h0;
    model_key(1);
    check("postreset_digits", digits, model_digits());
    model_press(12, 25);

`ifdef KEY_REPEAT_EN
    rep_exp = '{19, 119, 169, 219, 269};
    key_pins(5, c_v, r_v);
    press(c_v, r_v, 279, 40);
    check("repeat_kv_count", kv_n, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("repeat_kv_cycle%0d", i), (kv_cyc.size() > i) ? kv_cyc[i] : -1, rep_exp[i]);
    check("repeat_digits", digits, 16'h5555);
    check("repeat_digit_count", digit_count, 4);
    check("repeat_set_error", se_n, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_entry_decoder.md
Name: key_entry_decoder

Overview:
- Downstream consumer of the keypad scanner.
- Takes the scanner's `key_pressed_flag`, `col_val` and `row_val` (active-low one-hot) and turns them into clean single-cycle key events with a 4-bit key code.
- Runs an HHMM time-entry buffer: digits shift in, `A` commits, `B` backspaces, `C` clears.
- A validated commit produces hour/minute BCD values for the clock's time-set logic.

Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive `clk` cycles the synced flag must hold high (press) or low (release) before the level is accepted.
- `CNT_W`, 16: width of the debounce/repeat counter. Must hold `DEBOUNCE_CYCLES`, `REPEAT_DELAY` and `REPEAT_PERIOD`.
- `REPEAT_DELAY`, 5000: cycles from the first event to the first auto-repeat. Used only with `KEY_REPEAT_EN`.
- `REPEAT_PERIOD`, 1000: cycles between subsequent auto-repeats. Used only with `KEY_REPEAT_EN`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_pressed_flag`  in  1  scanner press flag; asynchronous to `clk`.
- `col_val`  in  4  scanner column, active-low one-hot; stable while the flag is high.
- `row_val`  in  4  scanner row, active-low one-hot; stable while the flag is high.
- `key_valid`  out  1  one-cycle pulse per accepted key event.
- `key_code`  out  4  code of the last event; held between events.
- `digits`  out  16  entry buffer as 4 BCD nibbles: [15:12] first digit entered, [3:0] last.
- `digit_count`  out  3  number of digits entered, 0..4.
- `set_valid`  out  1  one-cycle pulse on a successful commit.
- `set_hour`  out  8  committed hour, BCD; held until the next commit.
- `set_min`  out  8  committed minute, BCD; held until the next commit.
- `set_error`  out  1  one-cycle pulse on a rejected commit or a digit entered when the buffer is full.

Behaviour:
- Reset (async, `rst` = 1): every output is 0, both FSMs are in their initial state, all counters are 0, and the synchroniser flops are 0.
- Synchroniser: 2-flop sync of `key_pressed_flag` gives `flag_s`. `col_val`/`row_val` are sampled only inside the debounced window, so they need no synchroniser.
- Key map, with c = index of the 0 bit in `col_val` and r = index of the 0 bit in `row_val`:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- Invalid pattern: any value that is not exactly one zero bit in each of `col_val` and `row_val` produces no event.
- Event FSM, one transition per `clk`:
  - WAIT_PRESS: counter held at 0. `flag_s` = 1 goes to DEBOUNCE_P.
  - DEBOUNCE_P: counter increments while `flag_s` = 1. `flag_s` = 0 returns to WAIT_PRESS with counter cleared. When the counter reaches `DEBOUNCE_CYCLES`-1 with `flag_s` = 1, go to EMIT and sample/decode `col_val`/`row_val`.
  - EMIT: exactly 1 cycle. If the decode is valid, `key_valid` = 1 and `key_code` is updated; if invalid, both are unchanged. Next state is HOLD.
  - HOLD: `flag_s` = 0 goes to DEBOUNCE_R.
  - DEBOUNCE_R: `flag_s` returning to 1 goes back to HOLD. `DEBOUNCE_CYCLES` consecutive low cycles go to WAIT_PRESS.
- Latency: `key_valid` rises 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles after `key_pressed_flag` rises.
- Entry logic acts in the cycle after `key_valid`. Outputs are registered, so `set_valid`/`set_error`/buffer changes appear 1 cycle after `key_valid`.
  - Digit 0-9 with `digit_count` < 4: shift into `digits` (old content moves left by one nibble, new digit in [3:0]) and increment `digit_count`.
  - Digit 0-9 with `digit_count` == 4: `set_error` pulse, buffer unchanged.
  - `A` (commit): requires `digit_count` == 4, HH (`digits`[15:8]) ≤ 0x23 and MM (`digits`[7:0]) ≤ 0x59. On success: `set_hour` = HH, `set_min` = MM, `set_valid` pulse, buffer and count cleared. On failure: `set_error` pulse, buffer retained.
  - `B` (backspace): if `digit_count` > 0, shift `digits` right by one nibble (zero-fill [15:12]) and decrement; if count is 0, no-op.
  - `C`: clear `digits` and `digit_count`.
  - `D`/`E`/`F`: ignored; `key_valid` still pulses.
- Boundaries:
  - `set_valid` and `set_error` never assert in the same cycle.
  - A scanner flag glitch shorter than `DEBOUNCE_CYCLES` produces no event.
  - Holding a key produces exactly one event, unless `KEY_REPEAT_EN` is defined.
  - Reset mid-debounce or mid-entry abandons everything; no pulse is emitted.

Optional Feature:
- Macro: `KEY_REPEAT_EN`.
- Defined: in HOLD, the counter counts while `flag_s` = 1. After `REPEAT_DELAY` cycles from EMIT, and then every `REPEAT_PERIOD` cycles, `key_valid` re-pulses with the same `key_code`, and the entry logic processes each repeat as a new key. Any release resets the repeat counter.
- Undefined: HOLD only waits for release; there is no repeat logic or counter.

Test Plan:
- Reset, then flag high with `col_val` = 1101 and `row_val` = 1011 held for 40 cycles → one `key_valid` pulse at cycle 2+16+1 after the flag rises, `key_code` = 8.
- Flag pulses 10 cycles high, then low → no `key_valid`; FSM returns to WAIT_PRESS.
- Keys 1,2,3,0 then A → `digits` = 0x1230, then `set_valid` with `set_hour` = 0x12, `set_min` = 0x30; `digit_count` = 0 afterwards.
- Keys 2,5,0,0,A → `set_error` pulse, `digits` stays 0x2500. Then B,B → `digits` = 0x0025, `digit_count` = 2. Then C → 0, 0.
- Five digit presses 1,1,1,1,9 → `set_error` on the 5th, `digits` = 0x1111.
- With `KEY_REPEAT_EN`, `REPEAT_DELAY` = 100, `REPEAT_PERIOD` = 50, key 5 held 260 cycles past EMIT → `key_valid` at EMIT, +100, +150, +200, +250; `digit_count` saturates at 4 and `set_error` pulses on the 5th event.
